// File: rtl/controller_cfg_pkg.sv
// controller_cfg_pkg: address map, CTL bit positions, FSM states and poll schedule for controller_cfg.
package controller_cfg_pkg;
  localparam logic [9:0] ADDR_CTL            = 10'h000;
  localparam logic [9:0] ADDR_STATUS         = 10'h001;
  localparam logic [9:0] ADDR_ECAT_SYNC_TIME = 10'h011;
  localparam logic [9:0] ADDR_MOD_CYCLE      = 10'h020;
  localparam logic [9:0] ADDR_MOD_FREQ_DIV   = 10'h021;
  localparam logic [9:0] ADDR_SILENT_CYCLE   = 10'h030;
  localparam logic [9:0] ADDR_SILENT_STEP    = 10'h031;
  localparam logic [9:0] ADDR_STM_CYCLE      = 10'h040;
  localparam logic [9:0] ADDR_STM_FREQ_DIV   = 10'h041;
  localparam logic [9:0] ADDR_SOUND_SPEED    = 10'h043;
  localparam logic [9:0] BASE_CYCLE          = 10'h100;
  localparam logic [9:0] BASE_DELAY          = 10'h200;
  localparam int CTL_FORCE_FAN = 0;
  localparam int CTL_SYNC      = 1;
  localparam logic [3:0] POLL_STATUS_SLOT = 4'd11;
  typedef enum logic [1:0] {IDLE_POLL, SYNC_LOAD, SYNC_DONE} state_t;
  // Slots 0..10 read CTL and the polled registers, slot 11 is the STATUS write slot, 12..15 idle.
  function automatic logic [9:0] poll_addr(input logic [3:0] idx);
    return idx == 4'd0 ? ADDR_CTL :
           idx < 4'd4  ? ADDR_MOD_CYCLE + 10'(idx - 4'd1) :
           idx < 4'd6  ? ADDR_SILENT_CYCLE + 10'(idx - 4'd4) :
           idx < POLL_STATUS_SLOT ? ADDR_STM_CYCLE + 10'(idx - 4'd6) : ADDR_STATUS;
  endfunction
endpackage

// File: rtl/controller_cfg_if.sv
// controller_cfg_if: CPU access port of the configuration RAM (2-cycle read latency).
interface controller_cfg_if;
  logic        CPU_EN;
  logic        CPU_WE;
  logic [9:0]  CPU_ADDR;
  logic [15:0] CPU_DIN;
  logic [15:0] CPU_DOUT;
  modport master(output CPU_EN, CPU_WE, CPU_ADDR, CPU_DIN, input CPU_DOUT);
  modport slave(input CPU_EN, CPU_WE, CPU_ADDR, CPU_DIN, output CPU_DOUT);
endinterface

// File: rtl/cfg_bram.sv
// cfg_bram: true dual-port 1024x16 RAM, 2-cycle read latency on both ports, read-before-write.
module cfg_bram (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_a_en,
  input  logic        i_a_we,
  input  logic [9:0]  i_a_addr,
  input  logic [15:0] i_a_din,
  output logic [15:0] o_a_dout,
  input  logic        i_b_en,
  input  logic        i_b_we,
  input  logic [9:0]  i_b_addr,
  input  logic [15:0] i_b_din,
  output logic [15:0] o_b_dout
);
  logic [15:0] r_mem [0:1023];
  logic [15:0] r_a1, r_b1;
  always_ff @(posedge clk) begin
    if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_din;
    if (i_b_en && i_b_we) r_mem[i_b_addr] <= i_b_din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a1 <= '0;
      r_b1 <= '0;
      o_a_dout <= '0;
      o_b_dout <= '0;
    end else begin
      if (i_a_en) r_a1 <= r_mem[i_a_addr];
      if (i_b_en) r_b1 <= r_mem[i_b_addr];
      o_a_dout <= r_a1;
      o_b_dout <= r_b1;
    end
  end
endmodule

// File: rtl/controller_cfg.sv
// controller_cfg: configuration RAM owner; polls port B and decodes it into controller parameters.
// Define CONTROLLER_CFG_THERMO_STATUS_EN to mirror THERMO into STATUS once per poll loop.
module controller_cfg
  import controller_cfg_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic                        CLK,
  input  logic                        RST,
  controller_cfg_if.slave             cpu,
  input  logic                        THERMO,
  output logic                        FORCE_FAN,
  output logic [63:0]                 ECAT_SYNC_TIME,
  output logic                        SYNC_SET,
  output logic [15:0]                 CYCLE_M,
  output logic [31:0]                 FREQ_DIV_M,
  output logic [DEPTH-1:0][15:0]      DELAY_M,
  output logic [15:0]                 CYCLE_S,
  output logic [WIDTH-1:0]            STEP_S,
  output logic [15:0]                 CYCLE_STM,
  output logic [31:0]                 FREQ_DIV_STM,
  output logic [31:0]                 SOUND_SPEED,
  output logic [DEPTH-1:0][WIDTH-1:0] CYCLE
);
  localparam logic [9:0] SYNC_WORDS = 10'(4 + 2 * DEPTH);
  localparam logic [9:0] CYCLE_END  = 10'(4 + DEPTH);
  localparam logic [9:0] LAST_ADDR  = BASE_DELAY + 10'(DEPTH - 1);
  state_t                      r_state;
  logic [3:0]                  r_poll_idx;
  logic [9:0]                  r_sync_idx;
  logic                        r_sync_prev;
  logic                        r_tag_v1, r_tag_v2;
  logic [9:0]                  r_tag_a1, r_tag_a2;
  logic [15:0]                 r_lo;
  logic [63:0]                 r_sh_ecat;
  logic [DEPTH-1:0][WIDTH-1:0] r_sh_cycle;
  logic [DEPTH-1:0][15:0]      r_sh_delay;
  logic                        w_poll_rd, w_sync_rd, w_b_en, w_b_we;
  logic [9:0]                  w_b_addr, w_sync_addr, w_ecat_off;
  logic [15:0]                 w_b_din, w_q;
  assign w_poll_rd   = r_state == IDLE_POLL && r_poll_idx < POLL_STATUS_SLOT;
  assign w_sync_rd   = r_state == SYNC_LOAD && r_sync_idx < SYNC_WORDS;
  assign w_sync_addr = r_sync_idx < 10'd4 ? ADDR_ECAT_SYNC_TIME + r_sync_idx :
                       r_sync_idx < CYCLE_END ? BASE_CYCLE + (r_sync_idx - 10'd4) :
                       BASE_DELAY + (r_sync_idx - CYCLE_END);
  assign w_b_addr    = r_state == SYNC_LOAD ? w_sync_addr : poll_addr(r_poll_idx);
  assign w_b_en      = w_poll_rd | w_sync_rd | w_b_we;
  assign w_ecat_off  = r_tag_a2 - ADDR_ECAT_SYNC_TIME;
`ifdef CONTROLLER_CFG_THERMO_STATUS_EN
  assign w_b_we  = r_state == IDLE_POLL && r_poll_idx == POLL_STATUS_SLOT;
  assign w_b_din = {15'b0, THERMO};
`else
  logic w_unused_thermo;
  assign w_unused_thermo = THERMO;
  assign w_b_we  = 1'b0;
  assign w_b_din = '0;
`endif
  cfg_bram u_bram (
    .clk(CLK), .rst(RST),
    .i_a_en(cpu.CPU_EN), .i_a_we(cpu.CPU_WE), .i_a_addr(cpu.CPU_ADDR),
    .i_a_din(cpu.CPU_DIN), .o_a_dout(cpu.CPU_DOUT),
    .i_b_en(w_b_en), .i_b_we(w_b_we), .i_b_addr(w_b_addr),
    .i_b_din(w_b_din), .o_b_dout(w_q)
  );
  // The tag pipeline follows each port-B read so returning data is decoded by its address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state        <= IDLE_POLL;
      r_poll_idx     <= '0;
      r_sync_idx     <= '0;
      r_sync_prev    <= 1'b0;
      r_tag_v1       <= 1'b0;
      r_tag_v2       <= 1'b0;
      r_tag_a1       <= '0;
      r_tag_a2       <= '0;
      r_lo           <= '0;
      r_sh_ecat      <= '0;
      r_sh_cycle     <= '0;
      r_sh_delay     <= '0;
      FORCE_FAN      <= 1'b0;
      ECAT_SYNC_TIME <= '0;
      SYNC_SET       <= 1'b0;
      CYCLE_M        <= '0;
      FREQ_DIV_M     <= '0;
      DELAY_M        <= '0;
      CYCLE_S        <= '0;
      STEP_S         <= '0;
      CYCLE_STM      <= '0;
      FREQ_DIV_STM   <= '0;
      SOUND_SPEED    <= '0;
      CYCLE          <= '0;
    end else begin
      r_tag_v1 <= w_poll_rd | w_sync_rd;
      r_tag_a1 <= w_b_addr;
      r_tag_v2 <= r_tag_v1;
      r_tag_a2 <= r_tag_a1;
      SYNC_SET <= 1'b0;
      if (r_state == IDLE_POLL) begin
        r_poll_idx <= r_poll_idx + 4'd1;
        if (r_tag_v2)
          case (r_tag_a2)
            ADDR_CTL: begin
              FORCE_FAN   <= w_q[CTL_FORCE_FAN];
              r_sync_prev <= w_q[CTL_SYNC];
              if (w_q[CTL_SYNC] && !r_sync_prev) begin
                r_state    <= SYNC_LOAD;
                r_sync_idx <= '0;
                r_poll_idx <= '0;
              end
            end
            ADDR_MOD_CYCLE:                                        CYCLE_M      <= w_q;
            ADDR_MOD_FREQ_DIV, ADDR_STM_FREQ_DIV, ADDR_SOUND_SPEED: r_lo         <= w_q;
            ADDR_MOD_FREQ_DIV + 10'd1:                             FREQ_DIV_M   <= {w_q, r_lo};
            ADDR_SILENT_CYCLE:                                     CYCLE_S      <= w_q;
            ADDR_SILENT_STEP:                                      STEP_S       <= w_q[WIDTH-1:0];
            ADDR_STM_CYCLE:                                        CYCLE_STM    <= w_q;
            ADDR_STM_FREQ_DIV + 10'd1:                             FREQ_DIV_STM <= {w_q, r_lo};
            ADDR_SOUND_SPEED + 10'd1:                              SOUND_SPEED  <= {w_q, r_lo};
            default: ;
          endcase
      end else if (r_state == SYNC_LOAD) begin
        if (w_sync_rd) r_sync_idx <= r_sync_idx + 10'd1;
        if (r_tag_v2) begin
          if (w_ecat_off < 10'd4) r_sh_ecat[{w_ecat_off[1:0], 4'b0000} +: 16] <= w_q;
          if (r_tag_a2[9:8] == BASE_CYCLE[9:8]) r_sh_cycle[r_tag_a2[7:0]] <= w_q[WIDTH-1:0];
          if (r_tag_a2[9:8] == BASE_DELAY[9:8]) r_sh_delay[r_tag_a2[7:0]] <= w_q;
          // Final DELAY word lands: publish every table at once, together with SYNC_SET.
          if (r_tag_a2 == LAST_ADDR) begin
            ECAT_SYNC_TIME   <= r_sh_ecat;
            CYCLE            <= r_sh_cycle;
            DELAY_M          <= r_sh_delay;
            DELAY_M[DEPTH-1] <= w_q;
            SYNC_SET         <= 1'b1;
            r_state          <= SYNC_DONE;
          end
        end
      end else begin
        r_state <= IDLE_POLL;
      end
    end
  end
endmodule

// File: tb/tb_controller_cfg.sv
// tb_controller_cfg: randomized self-checking bench; expectations come from a model of RAM contents.
module tb_controller_cfg;
  localparam int WIDTH = 13;
  localparam int DEPTH = 249;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic THERMO = 1'b0;
  logic FORCE_FAN, SYNC_SET;
  logic [63:0] ECAT_SYNC_TIME;
  logic [15:0] CYCLE_M, CYCLE_S, CYCLE_STM;
  logic [31:0] FREQ_DIV_M, FREQ_DIV_STM, SOUND_SPEED;
  logic [WIDTH-1:0] STEP_S;
  logic [DEPTH-1:0][15:0] DELAY_M;
  logic [DEPTH-1:0][WIDTH-1:0] CYCLE;
  int checks = 0;
  int errors = 0;
  logic [15:0] mem [0:1023];
  logic [63:0] exp_ecat;
  logic [DEPTH-1:0][WIDTH-1:0] exp_cycle;
  logic [DEPTH-1:0][15:0] exp_delay;

  always #5 CLK = ~CLK;

  controller_cfg_if cpu_if();

  controller_cfg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .cpu(cpu_if), .THERMO(THERMO),
    .FORCE_FAN(FORCE_FAN), .ECAT_SYNC_TIME(ECAT_SYNC_TIME), .SYNC_SET(SYNC_SET),
    .CYCLE_M(CYCLE_M), .FREQ_DIV_M(FREQ_DIV_M), .DELAY_M(DELAY_M),
    .CYCLE_S(CYCLE_S), .STEP_S(STEP_S), .CYCLE_STM(CYCLE_STM),
    .FREQ_DIV_STM(FREQ_DIV_STM), .SOUND_SPEED(SOUND_SPEED), .CYCLE(CYCLE)
  );

  task automatic cpu_write(input logic [9:0] a, input logic [15:0] d);
    @(negedge CLK);
    cpu_if.CPU_EN = 1'b1; cpu_if.CPU_WE = 1'b1; cpu_if.CPU_ADDR = a; cpu_if.CPU_DIN = d;
    @(negedge CLK);
    cpu_if.CPU_EN = 1'b0; cpu_if.CPU_WE = 1'b0;
    mem[a] = d;
  endtask

  task automatic cpu_read(input logic [9:0] a, output logic [15:0] d);
    @(negedge CLK);
    cpu_if.CPU_EN = 1'b1; cpu_if.CPU_WE = 1'b0; cpu_if.CPU_ADDR = a;
    @(negedge CLK);
    cpu_if.CPU_EN = 1'b0;
    @(negedge CLK);
    d = cpu_if.CPU_DOUT;
  endtask

  // What the tables must look like once a sync captures the current RAM contents.
  task automatic snapshot_tables();
    exp_ecat = {mem[10'h014], mem[10'h013], mem[10'h012], mem[10'h011]};
    for (int i = 0; i < DEPTH; i++) begin
      exp_cycle[i] = mem[10'h100 + i][WIDTH-1:0];
      exp_delay[i] = mem[10'h200 + i];
    end
  endtask

  task automatic test_reset();
    logic [9:0] addrs [15] = '{10'h000, 10'h011, 10'h012, 10'h013, 10'h014, 10'h020, 10'h021,
                               10'h022, 10'h030, 10'h031, 10'h040, 10'h041, 10'h042, 10'h043, 10'h044};
    for (int i = 0; i < 15; i++) cpu_write(addrs[i], 16'h0000);
    #1;
    checks++;
    if ({FORCE_FAN, SYNC_SET, CYCLE_M, FREQ_DIV_M, CYCLE_S, STEP_S, CYCLE_STM, FREQ_DIV_STM, SOUND_SPEED} !== '0) begin
      errors++; $display("FAIL reset_polled got %h want 0", {FORCE_FAN, SYNC_SET, CYCLE_M, FREQ_DIV_M, CYCLE_S, STEP_S, CYCLE_STM, FREQ_DIV_STM, SOUND_SPEED});
    end
    checks++;
    if (ECAT_SYNC_TIME !== 64'h0 || CYCLE !== '0 || DELAY_M !== '0) begin
      errors++; $display("FAIL reset_tables got ecat %h want 0 (or tables nonzero)", ECAT_SYNC_TIME);
    end
    checks++;
    if (cpu_if.CPU_DOUT !== 16'h0) begin errors++; $display("FAIL reset_dout got %h want 0", cpu_if.CPU_DOUT); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_registers();
    logic [9:0] addrs [10] = '{10'h020, 10'h021, 10'h022, 10'h030, 10'h031, 10'h040, 10'h041, 10'h042, 10'h043, 10'h044};
    logic [15:0] spec_vals [10] = '{16'h1234, 16'hBEEF, 16'hDEAD, 16'h0FA0, 16'h1ABC, 16'h8000, 16'h5678, 16'h1234, 16'hF00D, 16'hCAFE};
    logic [15:0] rd;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) cpu_write(addrs[i], r == 0 ? spec_vals[i] : 16'($urandom));
      cpu_write(10'h000, r == 1 ? 16'h0001 : 16'h0000);
      repeat (r == 0 ? 100 : 32) @(negedge CLK);
      checks++;
      if (CYCLE_M !== mem[10'h020]) begin errors++; $display("FAIL reg_cycle_m r%0d got %h want %h", r, CYCLE_M, mem[10'h020]); end
      checks++;
      if (FREQ_DIV_M !== {mem[10'h022], mem[10'h021]}) begin errors++; $display("FAIL reg_freq_div_m r%0d got %h want %h", r, FREQ_DIV_M, {mem[10'h022], mem[10'h021]}); end
      checks++;
      if (CYCLE_S !== mem[10'h030]) begin errors++; $display("FAIL reg_cycle_s r%0d got %h want %h", r, CYCLE_S, mem[10'h030]); end
      checks++;
      if (STEP_S !== mem[10'h031][WIDTH-1:0]) begin errors++; $display("FAIL reg_step_s r%0d got %h want %h", r, STEP_S, mem[10'h031][WIDTH-1:0]); end
      checks++;
      if (CYCLE_STM !== mem[10'h040]) begin errors++; $display("FAIL reg_cycle_stm r%0d got %h want %h", r, CYCLE_STM, mem[10'h040]); end
      checks++;
      if (FREQ_DIV_STM !== {mem[10'h042], mem[10'h041]}) begin errors++; $display("FAIL reg_freq_div_stm r%0d got %h want %h", r, FREQ_DIV_STM, {mem[10'h042], mem[10'h041]}); end
      checks++;
      if (SOUND_SPEED !== {mem[10'h044], mem[10'h043]}) begin errors++; $display("FAIL reg_sound_speed r%0d got %h want %h", r, SOUND_SPEED, {mem[10'h044], mem[10'h043]}); end
      checks++;
      if (FORCE_FAN !== mem[10'h000][0]) begin errors++; $display("FAIL reg_force_fan r%0d got %b want %b", r, FORCE_FAN, mem[10'h000][0]); end
      cpu_read(addrs[r], rd);
      checks++;
      if (rd !== mem[addrs[r]]) begin errors++; $display("FAIL cpu_readback r%0d got %h want %h", r, rd, mem[addrs[r]]); end
    end
  endtask

  // Watches a window after a sync request: counts SYNC_SET cycles and checks tables at the pulse.
  task automatic watch_sync(input string name, input int window, input int want_pulses);
    int pulses = 0;
    int k = 0;
    for (int c = 0; c < window; c++) begin
      @(negedge CLK);
      if (SYNC_SET) begin
        pulses++;
        checks++;
        if (ECAT_SYNC_TIME !== exp_ecat) begin errors++; $display("FAIL %s_ecat got %h want %h", name, ECAT_SYNC_TIME, exp_ecat); end
        checks++;
        if (CYCLE !== exp_cycle) begin
          for (int i = DEPTH - 1; i >= 0; i--) if (CYCLE[i] !== exp_cycle[i]) k = i;
          errors++; $display("FAIL %s_cycle idx %0d got %h want %h", name, k, CYCLE[k], exp_cycle[k]);
        end
        checks++;
        if (DELAY_M !== exp_delay) begin
          for (int i = DEPTH - 1; i >= 0; i--) if (DELAY_M[i] !== exp_delay[i]) k = i;
          errors++; $display("FAIL %s_delay idx %0d got %h want %h", name, k, DELAY_M[k], exp_delay[k]);
        end
      end
    end
    checks++;
    if (pulses != want_pulses) begin errors++; $display("FAIL %s_pulses got %0d want %0d", name, pulses, want_pulses); end
  endtask

  task automatic test_sync();
    cpu_write(10'h011, 16'hCDEF);
    cpu_write(10'h012, 16'h89AB);
    cpu_write(10'h013, 16'h4567);
    cpu_write(10'h014, 16'h0123);
    for (int i = 0; i < DEPTH; i++) begin
      cpu_write(10'(10'h100 + i), 16'($urandom));
      cpu_write(10'(10'h200 + i), 16'($urandom));
    end
    snapshot_tables();
    cpu_write(10'h000, 16'h0003);
    watch_sync("sync", 2 * DEPTH + 16 + 40, 1);
    checks++;
    if (FORCE_FAN !== 1'b1) begin errors++; $display("FAIL sync_force_fan got %b want 1", FORCE_FAN); end
    checks++;
    if (ECAT_SYNC_TIME !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL sync_time got %h want 0123456789abcdef", ECAT_SYNC_TIME); end
  endtask

  task automatic test_no_retrigger();
    cpu_write(10'h000, 16'h0000);
    repeat (40) @(negedge CLK);
    cpu_write(10'h000, 16'h0003);
    watch_sync("held", 5000, 1);
    for (int n = 0; n < 8; n++) begin
      cpu_write(10'(10'h100 + $urandom_range(0, DEPTH - 1)), 16'($urandom));
      cpu_write(10'(10'h200 + $urandom_range(0, DEPTH - 1)), 16'($urandom));
    end
    cpu_write(10'h012, 16'($urandom));
    snapshot_tables();
    cpu_write(10'h000, 16'h0001);
    repeat (40) @(negedge CLK);
    cpu_write(10'h000, 16'h0003);
    watch_sync("resync", 2 * DEPTH + 16 + 40, 1);
  endtask

  task automatic test_tables_stable();
    cpu_write(10'h105, ~mem[10'h105]);
    cpu_write(10'h205, ~mem[10'h205]);
    cpu_write(10'h011, ~mem[10'h011]);
    repeat (100) @(negedge CLK);
    checks++;
    if (CYCLE[5] !== exp_cycle[5]) begin errors++; $display("FAIL stable_cycle5 got %h want %h", CYCLE[5], exp_cycle[5]); end
    checks++;
    if (DELAY_M[5] !== exp_delay[5]) begin errors++; $display("FAIL stable_delay5 got %h want %h", DELAY_M[5], exp_delay[5]); end
    checks++;
    if (ECAT_SYNC_TIME !== exp_ecat) begin errors++; $display("FAIL stable_ecat got %h want %h", ECAT_SYNC_TIME, exp_ecat); end
  endtask

  task automatic test_reset_mid_sync();
    int pulses = 0;
    cpu_write(10'h000, 16'h0001);
    repeat (40) @(negedge CLK);
    cpu_write(10'h000, 16'h0003);
    repeat (150) @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if ({FORCE_FAN, SYNC_SET, CYCLE_M, FREQ_DIV_M, CYCLE_S, STEP_S, CYCLE_STM, FREQ_DIV_STM, SOUND_SPEED} !== '0) begin
      errors++; $display("FAIL midrst_polled got %h want 0", {FORCE_FAN, SYNC_SET, CYCLE_M, FREQ_DIV_M, CYCLE_S, STEP_S, CYCLE_STM, FREQ_DIV_STM, SOUND_SPEED});
    end
    checks++;
    if (ECAT_SYNC_TIME !== 64'h0 || CYCLE !== '0 || DELAY_M !== '0) begin
      errors++; $display("FAIL midrst_tables got ecat %h want 0 (or tables nonzero)", ECAT_SYNC_TIME);
    end
    cpu_write(10'h000, 16'h0000);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (SYNC_SET) pulses++;
    end
    RST = 1'b0;
    for (int c = 0; c < 2 * DEPTH + 100; c++) begin
      @(negedge CLK);
      if (SYNC_SET) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
    checks++;
    if (CYCLE !== '0 || ECAT_SYNC_TIME !== 64'h0) begin errors++; $display("FAIL midrst_aborted got ecat %h want 0", ECAT_SYNC_TIME); end
    checks++;
    if (CYCLE_M !== mem[10'h020] || SOUND_SPEED !== {mem[10'h044], mem[10'h043]}) begin
      errors++; $display("FAIL midrst_repoll got %h/%h want %h/%h", CYCLE_M, SOUND_SPEED, mem[10'h020], {mem[10'h044], mem[10'h043]});
    end
  endtask

  task automatic test_status();
    logic [15:0] rd;
`ifdef CONTROLLER_CFG_THERMO_STATUS_EN
    THERMO = 1'b1;
    repeat (32) @(negedge CLK);
    cpu_read(10'h001, rd);
    checks++;
    if (rd !== 16'h0001) begin errors++; $display("FAIL status_hot got %h want 0001", rd); end
    THERMO = 1'b0;
    repeat (32) @(negedge CLK);
    cpu_read(10'h001, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL status_cool got %h want 0000", rd); end
`else
    cpu_write(10'h001, 16'hA5A5);
    THERMO = 1'b1;
    repeat (40) @(negedge CLK);
    cpu_read(10'h001, rd);
    checks++;
    if (rd !== mem[10'h001]) begin errors++; $display("FAIL status_untouched got %h want %h", rd, mem[10'h001]); end
`endif
  endtask

  initial begin
    cpu_if.CPU_EN = 1'b0;
    cpu_if.CPU_WE = 1'b0;
    cpu_if.CPU_ADDR = '0;
    cpu_if.CPU_DIN = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    test_reset();
    test_registers();
    test_sync();
    test_no_retrigger();
    test_tables_stable();
    test_reset_mid_sync();
    test_status();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/controller_cfg.md
Name: controller_cfg

Overview:
- Configuration register block for the transducer controller.
- Owns a dual-port 16-bit configuration RAM: the CPU writes through port A, and the block polls the RAM through port B.
- Decodes the RAM contents into the parameter outputs used by the modulation, silencer, STM and PWM blocks.
- Per-transducer CYCLE/DELAY tables and ECAT_SYNC_TIME are latched only on a sync request; SYNC_SET pulses when they are valid.

Parameters:
- WIDTH, 13: bit width of per-transducer cycle and silencer step.
- DEPTH, 249: number of transducers.

Ports:
- CLK  in  1: system clock (20.48 MHz); all logic on its rising edge.
- RST  in  1: asynchronous active-high reset.
- CPU_EN  in  1: CPU port enable.
- CPU_WE  in  1: CPU write strobe, valid with CPU_EN.
- CPU_ADDR  in  10: CPU word address.
- CPU_DIN  in  16: CPU write data.
- CPU_DOUT  out  16: CPU read data, 2-cycle latency.
- THERMO  in  1: thermal alarm.
- FORCE_FAN  out  1: CTL bit0.
- ECAT_SYNC_TIME  out  64: EtherCAT sync time.
- SYNC_SET  out  1: one-cycle pulse, sync data latched.
- CYCLE_M  out  16; FREQ_DIV_M  out  32.
- DELAY_M  out  16 x DEPTH.
- CYCLE_S  out  16; STEP_S  out  WIDTH.
- CYCLE_STM  out  16; FREQ_DIV_STM  out  32.
- SOUND_SPEED  out  32.
- CYCLE  out  WIDTH x DEPTH.

Behaviour:
- Address map (16-bit words; multiword values little-endian, lowest address = bits 15:0):
  - 0x000 CTL: bit0 FORCE_FAN, bit1 SYNC.
  - 0x001 STATUS.
  - 0x011–0x014 ECAT_SYNC_TIME.
  - 0x020 CYCLE_M; 0x021–0x022 FREQ_DIV_M.
  - 0x030 CYCLE_S; 0x031 STEP_S (low WIDTH bits).
  - 0x040 CYCLE_STM; 0x041–0x042 FREQ_DIV_STM; 0x043–0x044 SOUND_SPEED.
  - 0x100+i CYCLE[i] (low WIDTH bits).
  - 0x200+i DELAY[i].
- Reset: every output 0; internal sync-edge flag 0. RST mid-sequence aborts the sequence and no SYNC_SET is issued. RAM contents are not cleared.
- Port B read latency is 2 cycles; reads are pipelined one address per cycle.
- FSM states: IDLE_POLL, SYNC_LOAD, SYNC_DONE.
- IDLE_POLL:
  - Cycles through CTL plus the 0x020–0x044 registers in a 16-cycle loop.
  - Each output updates when its last word arrives; 32-bit values update atomically from both words.
  - Every CPU write to these registers is reflected on the outputs within 32 CLK cycles.
- Sync trigger: a CTL read with bit1=1 while the previous CTL read had bit1=0 enters SYNC_LOAD. A held bit1 does not retrigger.
- SYNC_LOAD:
  - Reads 0x011–0x014, then CYCLE[0..DEPTH-1], then DELAY[0..DEPTH-1].
  - Latches into shadow registers; ECAT_SYNC_TIME, CYCLE and DELAY_M update together when the last word lands.
- SYNC_DONE:
  - SYNC_SET is high for exactly 1 cycle, and outputs are already valid in that cycle.
  - Returns to IDLE_POLL.
  - Total time from the triggering CTL read to SYNC_SET is ≤ 2*DEPTH+16 cycles.
- During SYNC_LOAD, polled registers hold their values. CPU writes are always accepted, and polling resumes afterwards.
- CPU write and port-B access to the same address in the same cycle: port B returns the old data.
- CYCLE/DELAY/ECAT_SYNC_TIME never change outside a sync sequence.

Optional Feature:
- CONTROLLER_CFG_THERMO_STATUS_EN defined: each poll loop, port B writes STATUS (0x001) = {15'b0, THERMO}. THERMO is visible to the CPU within 32 cycles.
- Macro undefined: STATUS is never written by the block, and the THERMO input is unused.

Decomposition:
- Package controller_cfg_pkg:
  - Address constants (ADDR_CTL, ADDR_STATUS, ADDR_ECAT_SYNC_TIME, ADDR_MOD_CYCLE, ..., BASE_CYCLE, BASE_DELAY).
  - CTL bit indices.
  - FSM state enum.
- One sub-module, cfg_bram: true dual-port 1024x16 RAM with 2-cycle read latency on both ports.

Test Plan:
- Reset: assert RST mid-operation -> all outputs 0 and SYNC_SET 0 while RST is high.
- Register write: write CYCLE_M=0x1234, FREQ_DIV_M=0xDEADBEEF, CYCLE_S=0x0FA0, STEP_S=0x1ABC, CYCLE_STM=0x8000, FREQ_DIV_STM=0x12345678, SOUND_SPEED=0xCAFEF00D, then wait 100 cycles -> each output equals the written value.
- Sync:
  - Write ECAT_SYNC_TIME=0x0123456789ABCDEF, random CYCLE[i] and DELAY[i], then CTL=0x0003.
  - Required: FORCE_FAN=1, a single SYNC_SET pulse, and at the pulse all 249 CYCLE/DELAY entries plus the sync time match.
- No retrigger: hold CTL=0x0003 for 5000 cycles -> exactly one SYNC_SET. Clear bit1, then set it again -> second pulse.
- Tables stable: change CYCLE[5] without a sync -> the CYCLE[5] output is unchanged.
- Status (macro on): THERMO=1 -> CPU read of 0x001 returns 0x0001 within 32 cycles.
